// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over raster-ordered pixels with a half-row line buffer.
// Optional build macro MAXPOOL_AVG_EN adds avg_mode (per-frame 2x2 average instead of max).
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
`ifdef MAXPOOL_AVG_EN
    ,
    input  logic                         avg_mode
`endif
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MAXPOOL_AVG_EN
    localparam int BW    = DATA_WIDTH + 1;
    localparam int SW    = BW + 1;
`else
    localparam int BW    = DATA_WIDTH;
`endif

    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic signed [DATA_WIDTH-1:0] pair_hold_q, pair_hold_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic signed [BW-1:0]         lbuf_q [DEPTH];

    logic                         accept;
    logic                         lb_we;
    logic [PW-1:0]                pair_idx;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [BW-1:0]         pair_w;
    logic signed [BW-1:0]         buf_rd;
    logic signed [BW-1:0]         win_max;
    logic signed [DATA_WIDTH-1:0] result;
`ifdef MAXPOOL_AVG_EN
    logic                         avg_q, avg_d;
    logic signed [SW-1:0]         sum4;
`endif

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign pair_idx  = PW'(col_q >> 1);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Datapath: horizontal pair from the held even-column pixel, then vertical merge with the buffer.
    always_comb begin
        pair_max = (in_data > pair_hold_q) ? in_data : pair_hold_q;
`ifdef MAXPOOL_AVG_EN
        pair_w   = avg_q ? (BW'(in_data) + BW'(pair_hold_q)) : BW'(pair_max);
`else
        pair_w   = pair_max;
`endif
        buf_rd   = lbuf_q[pair_idx];
        win_max  = (buf_rd > pair_w) ? buf_rd : pair_w;
        result   = DATA_WIDTH'(win_max);
`ifdef MAXPOOL_AVG_EN
        sum4     = SW'(buf_rd) + SW'(pair_w);
        if (avg_q) begin
            result = DATA_WIDTH'(sum4 >>> 2);
        end
`endif
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        col_d       = col_q;
        row_d       = row_q;
        pair_hold_d = pair_hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        lb_we       = 1'b0;
`ifdef MAXPOOL_AVG_EN
        avg_d       = avg_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (!col_q[0]) begin
                pair_hold_d = in_data;
`ifdef MAXPOOL_AVG_EN
                if (col_q == '0 && row_q == '0) begin
                    avg_d = avg_mode;
                end
`endif
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // A new result may overwrite a beat consumed this same cycle: no bubble.
                out_data_d  = result;
                out_valid_d = 1'b1;
                out_last_d  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_hold_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef MAXPOOL_AVG_EN
            avg_q       <= 1'b0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_hold_q <= pair_hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef MAXPOOL_AVG_EN
            avg_q       <= avg_d;
`endif
        end
    end

    // NOTE: the line buffer is not reset; every entry is written on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[pair_idx] <= pair_w;
        end
    end

endmodule
